scan_sequencer: RTL and testbench
=================================

Name: scan_sequencer

Overview:
- Sequential index generator that drives the select/enable inputs of the n-bit one-hot decoder stage (decoder_nbit): sel feeds its `a`, enable feeds its `enable`.
- Steps sel through 0 .. 2**N-1, holding each value for a programmable dwell time, in one-shot or continuous mode.
- Used for LED/row scanning and round-robin selection.

Parameters:
- N, 3, width of sel; number of scanned indices = 2**N.
- DWELL_W, 8, width of dwell input and internal dwell counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  level; sampled high in IDLE begins a scan.
- stop  input  1  level; sampled high in SCAN aborts the scan.
- continuous  input  1  1 = wrap and rescan after last index; 0 = one-shot.
- dwell  input  DWELL_W  cycles per index; latched on start; 0 treated as 1.
- sel  output  N  current index to decoder.
- enable  output  1  high while scanning; decoder output valid.
- busy  output  1  high in SCAN state.
- done  output  1  one-cycle pulse at end of one-shot scan.
- wrap  output  1  one-cycle pulse when continuous scan returns to index 0.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, sel=0, enable=0, busy=0, done=0, wrap=0, dwell_cnt=0, dwell_lat=0. Release is synchronous to the next clk edge.
- All outputs are registered, with no combinational path from inputs to outputs.
- States: IDLE, SCAN.
- IDLE:
  - start=1 and stop=0 → next cycle SCAN.
  - In that cycle: sel=0, enable=1, busy=1, dwell_cnt=1, dwell_lat = (dwell==0) ? 1 : dwell.
  - Otherwise remain IDLE with enable=0, busy=0.
- SCAN, priority order:
  1. stop=1 → next cycle IDLE with sel=0, enable=0, busy=0. No done, no wrap.
  2. dwell_cnt < dwell_lat → dwell_cnt+1; sel holds.
  3. dwell_cnt == dwell_lat and sel < 2**N-1 → sel+1, dwell_cnt=1.
  4. dwell_cnt == dwell_lat and sel == 2**N-1:
     - continuous=1 (sampled this cycle) → sel=0, dwell_cnt=1, wrap=1 for one cycle, stay SCAN.
     - continuous=0 → IDLE: sel=0, enable=0, busy=0, done=1 for one cycle.
- Timing:
  - start is ignored while in SCAN.
  - dwell changes mid-scan have no effect until the next start.
  - One-shot timing: enable high for exactly 2**N × dwell_lat cycles. The done pulse coincides with the first cycle of enable=0.
- Arithmetic and widths:
  - sel increments modulo 2**N only via the explicit wrap path; no overflow beyond N bits.
  - dwell_cnt is DWELL_W bits; its maximum value equals dwell_lat ≤ 2**DWELL_W-1, so it never overflows.
- Restart: start may be asserted in the same cycle done=1 is observed (state is already IDLE). It is accepted at that edge, and the next cycle is SCAN with sel=0.
- Reset mid-scan: all outputs immediately return to reset values, with no done or wrap pulse.
- done and wrap are never high in the same cycle, and never high while stop aborts.

Test Plan:
- Reset: hold reset_n=0 mid-scan (sel=5, enable=1) → sel=0, enable=0, busy=0, done=0 immediately, without waiting for a clk edge.
- One-shot, N=3, dwell=2, continuous=0, start pulse → sel sequence 0,0,1,1,…,7,7 with enable=1 for 16 cycles. Then done=1 for 1 cycle, enable=0, sel=0.
- dwell=0, one-shot → each index held 1 cycle, enable high for 8 cycles, done after index 7.
- Continuous, dwell=1 → sel 0..7 repeating, wrap=1 in each cycle sel returns to 0, done never asserted. Clear continuous during sel=3 → scan finishes at 7, then done=1.
- Abort: dwell=3, assert stop while sel=4 → next cycle IDLE, sel=0, enable=0, no done. Start and stop asserted together in IDLE → stays IDLE.
- Back-to-back: assert start in the done cycle → next cycle busy=1, sel=0. Change dwell from 2 to 5 mid-scan → dwell stays 2 until the next start.

Source files
------------

// File: rtl/scan_sequencer.sv
// Steps a one-hot decoder index through 0..2**N-1, holding each index for a latched dwell time.
// One-shot scans end with a done pulse; continuous scans pulse wrap on each return to index 0.
module scan_sequencer #(
  parameter int unsigned N       = 3,
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N-1:0]       sel,
  output logic               enable,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  localparam logic [N-1:0] SEL_LAST = '1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       sel_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_W-1:0] dwell_lat_q, dwell_lat_d;
  logic               enable_d, busy_d, done_d, wrap_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sel         <= '0;
      enable      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wrap        <= 1'b0;
      dwell_cnt_q <= '0;
      dwell_lat_q <= '0;
    end else begin
      state_q     <= state_d;
      sel         <= sel_d;
      enable      <= enable_d;
      busy        <= busy_d;
      done        <= done_d;
      wrap        <= wrap_d;
      dwell_cnt_q <= dwell_cnt_d;
      dwell_lat_q <= dwell_lat_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    sel_d       = sel;
    dwell_cnt_d = dwell_cnt_q;
    dwell_lat_d = dwell_lat_q;
    enable_d    = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    wrap_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d     = SCAN;
          sel_d       = '0;
          enable_d    = 1'b1;
          busy_d      = 1'b1;
          dwell_cnt_d = DWELL_W'(1);
          dwell_lat_d = (dwell == '0) ? DWELL_W'(1) : dwell;
        end
      end

      SCAN: begin
        enable_d = 1'b1;
        busy_d   = 1'b1;
        if (stop) begin
          state_d  = IDLE;
          sel_d    = '0;
          enable_d = 1'b0;
          busy_d   = 1'b0;
        end else if (dwell_cnt_q < dwell_lat_q) begin
          dwell_cnt_d = DWELL_W'(dwell_cnt_q + DWELL_W'(1));
        end else if (sel != SEL_LAST) begin
          sel_d       = N'(sel + N'(1));
          dwell_cnt_d = DWELL_W'(1);
        end else if (continuous) begin
          sel_d       = '0;
          dwell_cnt_d = DWELL_W'(1);
          wrap_d      = 1'b1;
        end else begin
          // End of a one-shot scan: done lands in the first cycle with enable low
          state_d  = IDLE;
          sel_d    = '0;
          enable_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_scan_sequencer;

  localparam int unsigned N       = 3;
  localparam int unsigned DWELL_W = 8;
  localparam int unsigned NIDX    = 1 << N;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start, stop, continuous;
  logic [DWELL_W-1:0] dwell;
  logic [N-1:0]       sel;
  logic               enable, busy, done, wrap;

  typedef struct {
    int         cyc;
    logic [N-1:0] sel;
    logic       en;
    logic       busy;
    logic       done;
    logic       wrap;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  scan_sequencer #(.N(N), .DWELL_W(DWELL_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .dwell      (dwell),
    .sel        (sel),
    .enable     (enable),
    .busy       (busy),
    .done       (done),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare the expectation queued for this cycle, if any
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      vectors++;
      if ({sel, enable, busy, done, wrap} !== {e.sel, e.en, e.busy, e.done, e.wrap}) begin
        miscompares++;
        $display("FAIL cycle %0d outputs: got sel=%0d en=%b busy=%b done=%b wrap=%b, want sel=%0d en=%b busy=%b done=%b wrap=%b",
                 cyc, sel, enable, busy, done, wrap, e.sel, e.en, e.busy, e.done, e.wrap);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input int s, input logic en, input logic bsy,
                            input logic dn, input logic wr);
    exp_t e;
    e.cyc  = cyc;
    e.sel  = N'(s);
    e.en   = en;
    e.busy = bsy;
    e.done = dn;
    e.wrap = wr;
    q.push_back(e);
  endtask

  task automatic expect_idle();
    expect_now(0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One full one-shot pass: each index held for deff cycles
  task automatic oneshot_body(input int deff);
    for (int i = 0; i < int'(NIDX); i++) begin
      for (int d = 0; d < deff; d++) begin
        expect_now(i, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
      end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    continuous = 1'b0;
    dwell      = '0;
    repeat (3) tick();
    expect_idle();
    reset_n = 1'b1;
    tick();
    expect_idle();
    tick();

    // One-shot, dwell=2
    start = 1'b1; dwell = 8'd2;
    tick();
    start = 1'b0;
    oneshot_body(2);
    expect_now(0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Back-to-back restart in the done cycle, dwell=0 behaves as 1
    start = 1'b1; dwell = 8'd0;
    tick();
    start = 1'b0;
    oneshot_body(1);
    expect_now(0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    expect_idle();
    tick();

    // Continuous, dwell=1: two full passes, then clear continuous at sel=3
    start = 1'b1; dwell = 8'd1; continuous = 1'b1;
    tick();
    start = 1'b0;
    for (int pass = 0; pass < 3; pass++) begin
      for (int i = 0; i < int'(NIDX); i++) begin
        expect_now(i, 1'b1, 1'b1, 1'b0, (i == 0 && pass > 0));
        if (pass == 2 && i == 3) continuous = 1'b0;
        tick();
      end
    end
    expect_now(0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    expect_idle();
    tick();

    // Abort with stop while sel=4, dwell=3
    start = 1'b1; dwell = 8'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int d = 0; d < 3; d++) begin
        expect_now(i, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
      end
    end
    expect_now(4, 1'b1, 1'b1, 1'b0, 1'b0);
    stop = 1'b1;
    tick();
    expect_idle();
    // start together with stop in IDLE is refused
    start = 1'b1;
    tick();
    expect_idle();
    tick();
    expect_idle();
    start = 1'b0; stop = 1'b0;
    tick();

    // Dwell change mid-scan is ignored until the next start
    start = 1'b1; dwell = 8'd2;
    tick();
    start = 1'b0; dwell = 8'd5;
    oneshot_body(2);
    expect_now(0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    expect_idle();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int d = 0; d < 5; d++) begin
        expect_now(i, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
      end
    end
    expect_now(5, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();

    // Asynchronous reset mid-scan (sel=5): outputs clear before any clock edge
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({sel, enable, busy, done, wrap} !== {N'(0), 4'b0000}) begin
      miscompares++;
      $display("FAIL async_reset: got sel=%0d en=%b busy=%b done=%b wrap=%b, want all zero",
               sel, enable, busy, done, wrap);
    end
    tick();
    expect_idle();
    reset_n = 1'b1;
    tick();
    expect_idle();
    repeat (3) tick();

    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_expectations: got %0d unchecked, want 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
